// File: rtl/mdu_sequencer_pkg.sv
// Shared pipeline types for the execute-stage multiply/divide sequencer.
//   alufunc_t   : execute-stage ALU function code (5 bits)
//   mdu_state_t : sequencer FSM states
//   MDU_ITER_*  : iteration counts for 64-bit and word operations
//   is_*_op     : decode predicates on alufunc_t
package mdu_sequencer_pkg;

  typedef logic [63:0] word_t;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,
    ALU_SUB   = 5'd1,
    ALU_AND   = 5'd2,
    ALU_OR    = 5'd3,
    ALU_XOR   = 5'd4,
    ALU_SLL   = 5'd5,
    ALU_SRL   = 5'd6,
    ALU_SRA   = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_MUL   = 5'd16,
    ALU_DIV   = 5'd17,
    ALU_DIVU  = 5'd18,
    ALU_REM   = 5'd19,
    ALU_REMU  = 5'd20,
    ALU_MULW  = 5'd21,
    ALU_DIVW  = 5'd22,
    ALU_DIVUW = 5'd23,
    ALU_REMW  = 5'd24,
    ALU_REMUW = 5'd25
  } alufunc_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } mdu_state_t;

  localparam int unsigned MDU_ITER_D = 64;
  localparam int unsigned MDU_ITER_W = 32;

  function automatic logic is_mdu_op(input alufunc_t f);
    return (f >= ALU_MUL) && (f <= ALU_REMUW);
  endfunction

  function automatic logic is_mul_op(input alufunc_t f);
    return (f == ALU_MUL) || (f == ALU_MULW);
  endfunction

  function automatic logic is_word_op(input alufunc_t f);
    return (f >= ALU_MULW) && (f <= ALU_REMUW);
  endfunction

  // Signed divide/remainder: operands are treated as two's complement.
  function automatic logic is_signed_op(input alufunc_t f);
    return (f == ALU_DIV) || (f == ALU_REM) || (f == ALU_DIVW) || (f == ALU_REMW);
  endfunction

  function automatic logic is_rem_op(input alufunc_t f);
    return (f == ALU_REM) || (f == ALU_REMU) || (f == ALU_REMW) || (f == ALU_REMUW);
  endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Execute-stage <-> multiply/divide unit handshake.
//   valid_in, op, a, b, flush : request side (driven by the pipeline)
//   busy, done, result        : response side (driven by the sequencer)
// master = pipeline side, slave = sequencer side.
interface mdu_sequencer_if #(parameter int unsigned XLEN = 64);
  import mdu_sequencer_pkg::*;

  logic            valid_in;
  alufunc_t        op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output valid_in, op, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  valid_in, op, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/mdu_sequencer_div_core.sv
// Unsigned restoring divider datapath, one quotient bit per enable.
//   clk, reset        : clock, async active-high reset
//   load              : capture dividend/divisor, clear partial remainder
//   en                : perform one restoring step
//   dividend, divisor : unsigned operands (dividend is MSB-aligned by caller)
//   quo_next, rem_next: quotient/remainder after the current step
module mdu_div_core #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_next,
  output logic [XLEN-1:0] rem_next
);

  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            fits;

  // Shifted remainder needs one extra bit; a set top bit in the difference
  // means the trial subtraction underflowed and the remainder is restored.
  always_comb begin
    rem_sh   = {rem, quo[XLEN-1]};
    diff     = rem_sh - {1'b0, dvs};
    fits     = ~diff[XLEN];
    rem_next = fits ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_next = {quo[XLEN-2:0], fits};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (en) begin
      quo <= quo_next;
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV64 M-extension sequencer for the execute stage.
//   clk, reset : clock, async active-high reset
//   bus        : slave side of mdu_sequencer_if
//                (valid_in/op/a/b/flush in; busy/done/result out)
// MUL/MULW use inline shift-add, divides use mdu_div_core on magnitudes
// with sign fix-up here. Divide-by-zero and signed overflow bypass the
// iteration and complete on the accepting edge.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic           clk,
  input  logic           reset,
  mdu_sequencer_if.slave bus
);

  localparam int unsigned HALF = XLEN / 2;
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [HALF-1:0] MIN_W = {1'b1, {(HALF-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext_w(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  mdu_state_t state, state_next;

  logic [6:0]      cnt;
  alufunc_t        op_q;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] mcand, mplier, acc, acc_nxt;
  logic [XLEN-1:0] result_q, result_nxt;

  logic            in_w, in_sgn, in_rem, in_mul, in_div;
  logic            a_neg, b_neg, b_zero, ovf, shortcut, accept;
  logic [XLEN-1:0] a_mag, b_mag, a_res, special, dividend;
  logic [XLEN-1:0] quo_nxt, rem_nxt, q_fix, r_fix, d_sel;

  // Request decode, operand magnitudes and the shortcut results.
  always_comb begin
    in_w   = is_word_op(bus.op);
    in_sgn = is_signed_op(bus.op);
    in_rem = is_rem_op(bus.op);
    in_mul = is_mul_op(bus.op);
    in_div = is_mdu_op(bus.op) && !in_mul;

    a_neg = in_sgn && (in_w ? bus.a[HALF-1] : bus.a[XLEN-1]);
    b_neg = in_sgn && (in_w ? bus.b[HALF-1] : bus.b[XLEN-1]);

    a_mag = in_w ? {{HALF{1'b0}}, bus.a[HALF-1:0]} : bus.a;
    if (a_neg) a_mag = '0 - a_mag;
    if (in_w)  a_mag[XLEN-1:HALF] = '0;
    b_mag = in_w ? {{HALF{1'b0}}, bus.b[HALF-1:0]} : bus.b;
    if (b_neg) b_mag = '0 - b_mag;
    if (in_w)  b_mag[XLEN-1:HALF] = '0;

    b_zero = in_w ? (bus.b[HALF-1:0] == '0) : (bus.b == '0);
    ovf    = in_sgn && (in_w ? (bus.a[HALF-1:0] == MIN_W && bus.b[HALF-1:0] == '1)
                             : (bus.a == MIN_D && bus.b == '1));
    a_res  = in_w ? sext_w(bus.a[HALF-1:0]) : bus.a;
    if (b_zero) special = in_rem ? a_res : '1;
    else        special = in_rem ? '0 : a_res;

    shortcut = in_div && (b_zero || ovf);
    accept   = (state == S_IDLE) && bus.valid_in && is_mdu_op(bus.op) && !bus.flush;
    // Word dividends are MSB-aligned so 32 steps consume exactly their bits.
    dividend = in_w ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
  end

  mdu_div_core #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && in_div && !shortcut),
    .en       (state == S_DIV),
    .dividend (dividend),
    .divisor  (b_mag),
    .quo_next (quo_nxt),
    .rem_next (rem_nxt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Counter reaching 0 coincides with the edge entering S_DONE, so the
  // transition is taken while it still reads 1.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:
        if (accept) begin
          if (shortcut)    state_next = S_DONE;
          else if (in_mul) state_next = S_MUL;
          else             state_next = S_DIV;
        end
      S_MUL, S_DIV:
        if (bus.flush)        state_next = S_IDLE;
        else if (cnt == 7'd1) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy   = (state != S_IDLE);
    bus.done   = (state == S_DONE);
    bus.result = result_q;
  end

  // Result is formed from the final step's combinational values so it can be
  // registered on the same edge that enters S_DONE.
  always_comb begin
    acc_nxt = mplier[0] ? acc + mcand : acc;
    q_fix   = neg_q ? '0 - quo_nxt : quo_nxt;
    r_fix   = neg_r ? '0 - rem_nxt : rem_nxt;
    d_sel   = is_rem_op(op_q) ? r_fix : q_fix;
    unique case (state)
      S_IDLE:  result_nxt = special;
      S_MUL:   result_nxt = is_word_op(op_q) ? sext_w(acc_nxt[HALF-1:0]) : acc_nxt;
      S_DIV:   result_nxt = is_word_op(op_q) ? sext_w(d_sel[HALF-1:0]) : d_sel;
      default: result_nxt = result_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      op_q     <= ALU_ADD;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= bus.op;
        cnt    <= in_w ? 7'(MDU_ITER_W) : 7'(MDU_ITER_D);
        neg_q  <= a_neg ^ b_neg;
        neg_r  <= a_neg;
        mcand  <= bus.a;
        mplier <= in_w ? {{HALF{1'b0}}, bus.b[HALF-1:0]} : bus.b;
        acc    <= '0;
      end else if (state == S_MUL || state == S_DIV) begin
        cnt <= cnt - 7'd1;
        if (state == S_MUL) begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
      end
      if (state_next == S_DONE && state != S_DONE) result_q <= result_nxt;
    end
  end

endmodule
